// File: rtl/controle_multiciclo_pkg.sv
// Shared definitions for the multi-cycle RISC-V controller: state encoding,
// supported opcodes and ALU operation codes.
package controle_multiciclo_pkg;

  typedef enum logic [2:0] {
    BUSCA      = 3'd0,
    DECODIFICA = 3'd1,
    EXECUTA    = 3'd2,
    MEMORIA    = 3'd3,
    ESCRITA    = 3'd4,
    PARADO     = 3'd5
  } estado_t;

  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  function automatic logic opcode_conhecido(input logic [6:0] op);
    logic ok;
    case (op)
      OP_R, OP_I, OP_LW, OP_SW, OP_BEQ: ok = 1'b1;
      default:                          ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/contador_desempenho.sv
// Cycle and retired-instruction counters for the multi-cycle controller.
// Both wrap naturally at 2^LARGURA.
module contador_desempenho #(
  parameter int LARGURA = 32
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               conta_ciclo_i,
  input  logic               conta_instr_i,
  output logic [LARGURA-1:0] ciclos_o,
  output logic [LARGURA-1:0] instrucoes_o
);

  logic [LARGURA-1:0] ciclos_q, ciclos_d;
  logic [LARGURA-1:0] instr_q, instr_d;

  always_comb begin
    ciclos_d = ciclos_q;
    instr_d  = instr_q;
    if (conta_ciclo_i) ciclos_d = ciclos_q + LARGURA'(1);
    if (conta_instr_i) instr_d  = instr_q + LARGURA'(1);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      ciclos_q <= '0;
      instr_q  <= '0;
    end else begin
      ciclos_q <= ciclos_d;
      instr_q  <= instr_d;
    end
  end

  assign ciclos_o     = ciclos_q;
  assign instrucoes_o = instr_q;

endmodule

// File: rtl/controle_multiciclo.sv
// Multi-cycle sequencing controller: fetch/decode/execute/memory/write-back.
// Performance counters are built only when CONTROLE_CONTADORES_EN is defined.
module controle_multiciclo
  import controle_multiciclo_pkg::*;
#(
  parameter int LARGURA_CONT = 32
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [6:0]              opcode,
  input  logic                    aluZero,
  input  logic                    memPronto,
  input  logic                    fimArquivo,
  output logic                    escritaIR,
  output logic                    escritaPc,
  output logic                    pcFonte,
  output logic                    aluSrc,
  output logic [1:0]              aluOp,
  output logic                    leituraMem,
  output logic                    escritaMem,
  output logic                    memoriaParaReg,
  output logic                    escritaRegistrador,
  output logic                    parado,
  output logic [2:0]              estado,
  output logic [LARGURA_CONT-1:0] ciclos,
  output logic [LARGURA_CONT-1:0] instrucoes
);

  estado_t    state_q, state_d;
  logic [6:0] opreg_q, opreg_d;

  logic       esc_ir_c, esc_pc_c, pc_fonte_c, alu_src_c;
  logic [1:0] alu_op_c;
  logic       leit_mem_c, esc_mem_c, mem_reg_c, esc_reg_c, parado_c;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= BUSCA;
      opreg_q <= '0;
    end else begin
      state_q <= state_d;
      opreg_q <= opreg_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    opreg_d    = opreg_q;
    esc_ir_c   = 1'b0;
    esc_pc_c   = 1'b0;
    pc_fonte_c = 1'b0;
    alu_src_c  = 1'b0;
    alu_op_c   = ALUOP_ADD;
    leit_mem_c = 1'b0;
    esc_mem_c  = 1'b0;
    mem_reg_c  = 1'b0;
    esc_reg_c  = 1'b0;
    parado_c   = 1'b0;

    case (state_q)
      BUSCA: begin
        if (fimArquivo) begin
          state_d = PARADO;
        end else begin
          esc_ir_c = 1'b1;
          state_d  = DECODIFICA;
        end
      end

      DECODIFICA: begin
        opreg_d = opcode;
        if (opcode_conhecido(opcode)) begin
          state_d = EXECUTA;
        end else begin
          esc_pc_c = 1'b1;
          state_d  = BUSCA;
        end
      end

      EXECUTA: begin
        case (opreg_q)
          OP_R: begin
            alu_op_c = ALUOP_FUNCT;
            state_d  = ESCRITA;
          end
          OP_I: begin
            alu_src_c = 1'b1;
            alu_op_c  = ALUOP_FUNCT;
            state_d   = ESCRITA;
          end
          OP_LW, OP_SW: begin
            alu_src_c = 1'b1;
            state_d   = MEMORIA;
          end
          OP_BEQ: begin
            // Branch resolves here; the PC source follows the live zero flag.
            alu_op_c   = ALUOP_SUB;
            esc_pc_c   = 1'b1;
            pc_fonte_c = aluZero;
            state_d    = BUSCA;
          end
          default: state_d = BUSCA;
        endcase
      end

      MEMORIA: begin
        // Address operands held so the memory sees a stable address while waiting.
        alu_src_c = 1'b1;
        if (opreg_q == OP_LW) begin
          leit_mem_c = 1'b1;
          if (memPronto) state_d = ESCRITA;
        end else if (opreg_q == OP_SW) begin
          esc_mem_c = 1'b1;
          if (memPronto) begin
            esc_pc_c = 1'b1;
            state_d  = BUSCA;
          end
        end else begin
          state_d = BUSCA;
        end
      end

      ESCRITA: begin
        esc_reg_c = 1'b1;
        mem_reg_c = (opreg_q == OP_LW);
        esc_pc_c  = 1'b1;
        alu_src_c = (opreg_q != OP_R);
        alu_op_c  = (opreg_q == OP_LW) ? ALUOP_ADD : ALUOP_FUNCT;
        state_d   = BUSCA;
      end

      PARADO: parado_c = 1'b1;

      default: state_d = BUSCA;
    endcase
  end

  // Every output reads as zero while reset is held, whatever the current state.
  assign escritaIR          = esc_ir_c   & ~reset;
  assign escritaPc          = esc_pc_c   & ~reset;
  assign pcFonte            = pc_fonte_c & ~reset;
  assign aluSrc             = alu_src_c  & ~reset;
  assign aluOp              = reset ? 2'b00 : alu_op_c;
  assign leituraMem         = leit_mem_c & ~reset;
  assign escritaMem         = esc_mem_c  & ~reset;
  assign memoriaParaReg     = mem_reg_c  & ~reset;
  assign escritaRegistrador = esc_reg_c  & ~reset;
  assign parado             = parado_c   & ~reset;
  assign estado             = reset ? 3'd0 : state_q;

`ifdef CONTROLE_CONTADORES_EN
  logic [LARGURA_CONT-1:0] ciclos_w, instr_w;

  contador_desempenho #(
    .LARGURA (LARGURA_CONT)
  ) u_contador (
    .clock         (clock),
    .reset         (reset),
    .conta_ciclo_i (state_q != PARADO),
    .conta_instr_i (esc_pc_c),
    .ciclos_o      (ciclos_w),
    .instrucoes_o  (instr_w)
  );

  assign ciclos     = reset ? '0 : ciclos_w;
  assign instrucoes = reset ? '0 : instr_w;
`else
  assign ciclos     = '0;
  assign instrucoes = '0;
`endif

endmodule

// File: tb/tb_controle_multiciclo.sv
// Randomized scoreboard bench for controle_multiciclo; counter expectations
// follow whether CONTROLE_CONTADORES_EN is defined.
module tb_controle_multiciclo;

  localparam int LC = 32;
`ifdef CONTROLE_CONTADORES_EN
  localparam bit CONT_EN = 1'b1;
`else
  localparam bit CONT_EN = 1'b0;
`endif

  localparam logic [6:0] R_OP   = 7'b0110011;
  localparam logic [6:0] I_OP   = 7'b0010011;
  localparam logic [6:0] LW_OP  = 7'b0000011;
  localparam logic [6:0] SW_OP  = 7'b0100011;
  localparam logic [6:0] BEQ_OP = 7'b1100011;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic [6:0]    opcode = '0;
  logic          aluZero = 1'b0, memPronto = 1'b0, fimArquivo = 1'b0;
  logic          escritaIR, escritaPc, pcFonte, aluSrc;
  logic [1:0]    aluOp;
  logic          leituraMem, escritaMem, memoriaParaReg, escritaRegistrador, parado;
  logic [2:0]    estado;
  logic [LC-1:0] ciclos, instrucoes;

  controle_multiciclo #(.LARGURA_CONT(LC)) dut (
    .clock(clock), .reset(reset), .opcode(opcode), .aluZero(aluZero),
    .memPronto(memPronto), .fimArquivo(fimArquivo), .escritaIR(escritaIR),
    .escritaPc(escritaPc), .pcFonte(pcFonte), .aluSrc(aluSrc), .aluOp(aluOp),
    .leituraMem(leituraMem), .escritaMem(escritaMem), .memoriaParaReg(memoriaParaReg),
    .escritaRegistrador(escritaRegistrador), .parado(parado), .estado(estado),
    .ciclos(ciclos), .instrucoes(instrucoes)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, req, $time);
  endtask

  typedef struct {
    int         lat;
    logic       pcf;
    int         nleit;
    int         nesc;
    int         nreg;
    int         nm2r;
    logic [1:0] aop;
    logic       asrc;
    logic [2:0] est;
  } exp_t;

  exp_t sbq[$];

  // Reference: what one instruction should look like, from the instruction class alone.
  function automatic exp_t modelo(input logic [6:0] op, input logic az, input int w);
    exp_t e;
    e = '{lat: 2, pcf: 1'b0, nleit: 0, nesc: 0, nreg: 0, nm2r: 0,
          aop: 2'b00, asrc: 1'b0, est: 3'd1};
    if (op == R_OP || op == I_OP) begin
      e.lat = 4; e.nreg = 1; e.aop = 2'b10; e.asrc = (op == I_OP); e.est = 3'd4;
    end else if (op == LW_OP) begin
      e.lat = 5 + w; e.nleit = w + 1; e.nreg = 1; e.nm2r = 1; e.asrc = 1'b1; e.est = 3'd4;
    end else if (op == SW_OP) begin
      e.lat = 4 + w; e.nesc = w + 1; e.asrc = 1'b1; e.est = 3'd3;
    end else if (op == BEQ_OP) begin
      e.lat = 3; e.pcf = az; e.aop = 2'b01; e.est = 3'd2;
    end
    return e;
  endfunction

  // Monitor: gathers strobes per instruction and scores each retirement.
  int   cnt = 0, n_ir = 0, n_leit = 0, n_esc = 0, n_reg = 0, n_m2r = 0;
  logic [2:0] est_ir = '0;

  always @(negedge clock) begin
    if (reset) begin
      cnt = 0; n_ir = 0; n_leit = 0; n_esc = 0; n_reg = 0; n_m2r = 0;
      chk("reset_strobes", 64'({escritaIR, escritaPc, pcFonte, aluSrc, aluOp, leituraMem,
                                escritaMem, memoriaParaReg, escritaRegistrador, parado, estado}), 64'd0);
      chk("reset_counters", 64'(ciclos | instrucoes), 64'd0);
    end else if (!parado) begin
      if (escritaIR) begin
        cnt = 1; n_ir = 0; n_leit = 0; n_esc = 0; n_reg = 0; n_m2r = 0;
        est_ir = estado;
      end else begin
        cnt++;
      end
      n_ir   += int'(escritaIR);
      n_leit += int'(leituraMem);
      n_esc  += int'(escritaMem);
      n_reg  += int'(escritaRegistrador);
      n_m2r  += int'(memoriaParaReg);
      if (escritaPc) begin
        if (sbq.size() == 0) begin
          chk("unexpected_retire", 64'd1, 64'(sbq.size()));
        end else begin
          exp_t e;
          e = sbq.pop_front();
          chk("latency",      64'(cnt),    64'(e.lat));
          chk("pcFonte",      64'(pcFonte), 64'(e.pcf));
          chk("leituraMem_n", 64'(n_leit), 64'(e.nleit));
          chk("escritaMem_n", 64'(n_esc),  64'(e.nesc));
          chk("regwrite_n",   64'(n_reg),  64'(e.nreg));
          chk("memToReg_n",   64'(n_m2r),  64'(e.nm2r));
          chk("aluOp_ret",    64'(aluOp),  64'(e.aop));
          chk("aluSrc_ret",   64'(aluSrc), 64'(e.asrc));
          chk("estado_ret",   64'(estado), 64'(e.est));
          chk("fetch_once",   64'(n_ir),   64'd1);
          chk("estado_fetch", 64'(est_ir), 64'd0);
        end
        cnt = 0; n_ir = 0; n_leit = 0; n_esc = 0; n_reg = 0; n_m2r = 0;
      end
    end
  end

  int exp_cyc = 0;
  int exp_ins = 0;

  // Called at the start of a BUSCA cycle; returns at the start of the next one.
  task automatic run_instr(input logic [6:0] op, input logic az, input int w);
    exp_t e;
    int   c;
    logic done, is_mem;
    e = modelo(op, az, w);
    sbq.push_back(e);
    exp_cyc += e.lat;
    exp_ins++;
    is_mem = (op == LW_OP) || (op == SW_OP);
    c = 1;
    done = 1'b0;
    while (!done && c <= 60) begin
      opcode     = (c == 2) ? op : 7'($urandom);
      aluZero    = (c == 3) ? az : 1'($urandom);
      fimArquivo = (c == 1) ? 1'b0 : 1'($urandom);
      if (is_mem && c >= 4) memPronto = (c >= 4 + w);
      else                  memPronto = 1'($urandom);
      @(negedge clock);
      if (escritaPc) done = 1'b1;
      @(posedge clock);
      #1;
      c++;
    end
    chk("retired", 64'(done), 64'd1);
  endtask

  task automatic chk_counters(input string nm);
    chk({nm, "_ciclos"},     64'(ciclos),     CONT_EN ? 64'(exp_cyc) : 64'd0);
    chk({nm, "_instrucoes"}, 64'(instrucoes), CONT_EN ? 64'(exp_ins) : 64'd0);
  endtask

  function automatic logic [6:0] pick_op();
    case ($urandom_range(0, 5))
      0: return R_OP;
      1: return I_OP;
      2: return LW_OP;
      3: return SW_OP;
      4: return BEQ_OP;
      default: return 7'($urandom);
    endcase
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not end, expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;

    // Three back-to-back R instructions from reset: 12 cycles, 3 retirements.
    repeat (3) run_instr(R_OP, 1'b0, 0);
    chk_counters("three_r");

    run_instr(LW_OP, 1'b0, 2);
    run_instr(BEQ_OP, 1'b1, 0);
    run_instr(BEQ_OP, 1'b0, 0);
    run_instr(SW_OP, 1'b0, 0);
    run_instr(7'b1111111, 1'b0, 0);
    run_instr(I_OP, 1'b0, 0);
    run_instr(SW_OP, 1'b1, 3);

    for (int i = 0; i < 40; i++) run_instr(pick_op(), 1'($urandom), $urandom_range(0, 3));
    chk_counters("random");

    // Reset while a load is stalled in MEMORIA.
    opcode = LW_OP; memPronto = 1'b0; fimArquivo = 1'b0;
    repeat (3) begin @(posedge clock); #1; end
    @(negedge clock);
    chk("lw_waiting_read", 64'(leituraMem), 64'd1);
    chk("lw_waiting_estado", 64'(estado), 64'd3);
    @(posedge clock); #1;
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    exp_cyc = 0; exp_ins = 0;
    #1;
    chk("after_reset_estado", 64'(estado), 64'd0);
    chk("after_reset_regwrite", 64'(escritaRegistrador), 64'd0);
    run_instr(BEQ_OP, 1'b1, 0);
    run_instr(LW_OP, 1'b0, 1);
    chk_counters("post_reset");

    // Halt request in BUSCA; the transition cycle still counts as a cycle.
    fimArquivo = 1'b1;
    @(posedge clock); #1;
    exp_cyc++;
    for (int i = 0; i < 20; i++) begin
      opcode = 7'($urandom); memPronto = 1'($urandom);
      aluZero = 1'($urandom); fimArquivo = 1'($urandom);
      @(negedge clock);
      chk("halt_parado", 64'(parado), 64'd1);
      chk("halt_estado", 64'(estado), 64'd5);
      chk("halt_strobes", 64'({escritaIR, escritaPc, pcFonte, aluSrc, aluOp, leituraMem,
                               escritaMem, memoriaParaReg, escritaRegistrador}), 64'd0);
      @(posedge clock); #1;
    end
    chk_counters("halted");
    chk("scoreboard_drained", 64'(sbq.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/controle_multiciclo.md
# controle_multiciclo

Multi-cycle sequencing controller for the RISC-V datapath. It replaces the single-cycle `control` decoder when the datapath runs in multi-cycle mode. It steps every instruction through fetch, decode, execute, memory and write-back, and drives all datapath strobes and mux selects from a state register. It waits on a data-memory ready handshake and halts when the instruction stream ends.

## Interface
Parameters:
- `LARGURA_CONT`, 32, width of the performance counters.

Ports:
- `clock`  in  1  system clock, rising edge.
- `reset`  in  1  synchronous, active-high.
- `opcode`  in  7  instruction[6:0] from the instruction register.
- `aluZero`  in  1  ALU zero flag.
- `memPronto`  in  1  data memory has completed the current read or write.
- `fimArquivo`  in  1  instruction stream exhausted; halt request.
- `escritaIR`  out  1  load the instruction register.
- `escritaPc`  out  1  load the PC.
- `pcFonte`  out  1  PC source: 0 = PC+4, 1 = branch target.
- `aluSrc`  out  1  ALU operand B: 0 = rs2, 1 = immediate.
- `aluOp`  out  2  to the ALU control: 00 = add, 01 = sub, 10 = funct decode.
- `leituraMem` / `escritaMem`  out  1 each  data memory read / write strobes.
- `memoriaParaReg`  out  1  write-back source: 1 = memory, 0 = ALU.
- `escritaRegistrador`  out  1  register file write enable.
- `parado`  out  1  controller is halted.
- `estado`  out  3  current state, for debug.
- `ciclos`, `instrucoes`  out  `LARGURA_CONT` each  performance counters.

## Operation
- State encoding: BUSCA=0, DECODIFICA=1, EXECUTA=2, MEMORIA=3, ESCRITA=4, PARADO=5. Unused encodings go to BUSCA on the next edge.
- Supported opcodes:
  - R = 0110011
  - I = 0010011
  - LW = 0000011
  - SW = 0100011
  - BEQ = 1100011
- `opcode` is latched into an internal register (`opReg`) in DECODIFICA. All later states decode `opReg` only.

State behaviour:
- **BUSCA:**
  - If `fimArquivo`=1: go to PARADO with no strobes asserted.
  - Otherwise: `escritaIR`=1, go to DECODIFICA.
- **DECODIFICA:**
  - Known opcode: go to EXECUTA.
  - Unknown opcode: `escritaPc`=1 with `pcFonte`=0, go to BUSCA. The instruction retires as a NOP.
- **EXECUTA:**
  - R: `aluSrc`=0, `aluOp`=10, go to ESCRITA.
  - I: `aluSrc`=1, `aluOp`=10, go to ESCRITA.
  - LW or SW: `aluSrc`=1, `aluOp`=00, go to MEMORIA.
  - BEQ: `aluSrc`=0, `aluOp`=01, `escritaPc`=1, `pcFonte`=`aluZero` (combinational, Mealy), go to BUSCA.
- **MEMORIA:**
  - `aluSrc`/`aluOp` stay at 1/00 so the address remains stable.
  - LW: `leituraMem`=1 every cycle until `memPronto`=1, then go to ESCRITA.
  - SW: `escritaMem`=1 every cycle until `memPronto`=1. In that cycle also `escritaPc`=1, `pcFonte`=0, and go to BUSCA.
- **ESCRITA:**
  - `escritaRegistrador`=1, `memoriaParaReg`=(opReg==LW), `escritaPc`=1, `pcFonte`=0, go to BUSCA.
  - `aluSrc`/`aluOp` stay at their EXECUTA values.
- **PARADO:** all strobes 0, `parado`=1. Only `reset` leaves this state.

Defaults and boundary rules:
- Every strobe not listed for a state is 0.
- `fimArquivo` is sampled only in BUSCA. An instruction already in flight always completes.
- `memPronto` is ignored outside MEMORIA.

## Timing
- Reset values:
  - state = BUSCA, `opReg` = 0, counters = 0.
  - While `reset`=1, every output is forced to 0 (including `estado`), regardless of state.
- The first BUSCA cycle is the cycle after `reset` falls.
- Latency with `memPronto` tied to 1:
  - R/I: 4 cycles
  - LW: 5 cycles
  - SW: 4 cycles
  - BEQ: 3 cycles
  - unknown opcode: 2 cycles
- Each cycle `memPronto` is low in MEMORIA adds one cycle.
- Reset asserted mid-instruction: the next edge returns to BUSCA. No partial write-back occurs after that edge.
- `escritaPc` is high for exactly one cycle per retired instruction.

## Configuration
- `CONTROLE_CONTADORES_EN` defined:
  - `ciclos` increments every non-reset cycle outside PARADO.
  - `instrucoes` increments on every cycle with `escritaPc`=1.
  - Both wrap modulo 2^`LARGURA_CONT`.
- Not defined: both ports are constant 0 and no counter flops are built.

## Structure
- Package `controle_multiciclo_pkg` holds:
  - the state enum and its encodings;
  - the five opcode constants;
  - the `aluOp` codes.
- One sub-module, `contador_desempenho`, holds the two counters. It is instantiated only under `CONTROLE_CONTADORES_EN`.

## Test plan
- **R instruction:** reset, then `opcode`=0110011, `memPronto`=1 -> `estado` sequence 0,1,2,4,0. `escritaIR` high in cycle 1. Cycle 4 has `escritaRegistrador`=`escritaPc`=1, `aluOp`=10, `aluSrc`=0.
- **LW with wait:** `opcode`=0000011, `memPronto` low for 2 cycles -> `leituraMem` high for 3 cycles. Cycle 7 has `escritaRegistrador`=1 and `memoriaParaReg`=1.
- **BEQ:** with `aluZero`=1 -> cycle 3 has `escritaPc`=1, `pcFonte`=1. Repeated with `aluZero`=0 -> `pcFonte`=0. `escritaRegistrador` never asserts.
- **SW and unknown opcode:**
  - SW with `memPronto`=1 -> `escritaMem` and `escritaPc` both high in cycle 4, no register write.
  - `opcode`=1111111 -> `escritaPc` in cycle 2, nothing else.
- **Halt and reset:**
  - `fimArquivo`=1 in BUSCA -> `parado`=1 from the next cycle, all strobes 0 for 20 cycles.
  - `reset` pulsed during MEMORIA -> `estado`=0 after one edge.
- **Counters (macro defined):** three back-to-back R instructions -> `ciclos`=12, `instrucoes`=3. With the macro undefined, both read 0.
